// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] DEF_RESET_PC  = 32'h2000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_MISS = 2'd3
  } fetch_state_e;

  // Word-align a fetch target; the two low address bits carry no meaning.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory / icache bus between the fetch stage and the cache.
interface fetch_stage_if;

  logic [31:0] icache_addr;   // fetch address, data returns next cycle
  logic        icache_re;     // read enable
  logic [31:0] icache_dout;   // data for the address issued last cycle
  logic        icache_stall;  // miss: icache_dout not valid this cycle

  modport master (
    output icache_addr, icache_re,
    input  icache_dout, icache_stall
  );

  modport slave (
    input  icache_addr, icache_re,
    output icache_dout, icache_stall
  );

endinterface

// File: rtl/fetch_hold_buffer.sv
// Holds the fetched word while decode is stalled and selects between the
// held word and the live icache data.
module fetch_hold_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,     // latch live_instr and mark it held
  input  logic        clear,       // drop the held word
  input  logic [31:0] live_instr,
  output logic [31:0] instr_sel
);

  logic [31:0] hold_instr;
  logic        hold_valid;

  // Track whether a held word is pending.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst)          hold_valid <= 1'b0;
    else if (clear)   hold_valid <= 1'b0;
    else if (capture) hold_valid <= 1'b1;
  end

  // Capture the data word on a stall.
  always_ff @(posedge clk) begin
    // NOTE: the data register is not reset; hold_valid alone qualifies it,
    // so a reset here would only add logic.
    if (capture) hold_instr <= live_instr;
  end

  assign instr_sel = hold_valid ? hold_instr : live_instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the sync-read icache and
// presents {pc_out, instr_out, instr_valid} to decode. Handles decode stall,
// execute redirect, icache miss wait, and holds the fetched word while stalled.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        icache,
  output logic [31:0]          pc_out,
  output logic [31:0]          instr_out,
  output logic                 instr_valid
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_nxt;
  logic [31:0]  pc_inc;
  logic [31:0]  redirect_tgt;
  logic         capture;
  logic         clear;
  logic [31:0]  buf_instr;

  assign pc_inc       = pc_out + 32'd4;  // wraps mod 2^32
  assign redirect_tgt = align_pc(redirect_pc);

  // Next-PC mux, icache request and output qualification for each state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    state_nxt          = state;
    pc_nxt             = pc_out;
    icache.icache_addr = pc_out;
    icache.icache_re   = 1'b0;
    instr_valid        = 1'b0;
    capture            = 1'b0;
    clear              = 1'b0;

    if (rst) begin
      icache.icache_addr = RESET_PC;
    end else begin
      case (state)
        ST_BOOT: begin
          icache.icache_addr = RESET_PC;
          icache.icache_re   = 1'b1;
          state_nxt          = ST_RUN;
        end
        default: begin
          if (redirect) begin
            // Kill the wrong-path word and fetch the target.
            icache.icache_addr = redirect_tgt;
            icache.icache_re   = 1'b1;
            pc_nxt             = redirect_tgt;
            clear              = 1'b1;
            state_nxt          = ST_RUN;
          end else if (state == ST_HOLD) begin
            instr_valid = 1'b1;
            if (!stall) begin
              icache.icache_addr = pc_inc;
              icache.icache_re   = 1'b1;
              pc_nxt             = pc_inc;
              clear              = 1'b1;
              state_nxt          = ST_RUN;
            end
          end else if (icache.icache_stall) begin
            // RUN or MISS waiting on the cache: re-issue pc_out every cycle.
            icache.icache_re = 1'b1;
            state_nxt        = ST_MISS;
          end else begin
            // RUN, or MISS whose data just arrived.
            instr_valid = 1'b1;
            if (stall) begin
              capture   = 1'b1;
              state_nxt = ST_HOLD;
            end else begin
              icache.icache_addr = pc_inc;
              icache.icache_re   = 1'b1;
              pc_nxt             = pc_inc;
              state_nxt          = ST_RUN;
            end
          end
        end
      endcase
    end
  end

  // FSM state and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_BOOT;
      pc_out <= RESET_PC;
    end else begin
      state  <= state_nxt;
      pc_out <= pc_nxt;
    end
  end

  fetch_hold_buffer u_hold (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .clear      (clear),
    .live_instr (icache.icache_dout),
    .instr_sel  (buf_instr)
  );

  assign instr_out = instr_valid ? buf_instr : NOP_INSTR;

endmodule
